// File: rtl/fp_add_scheduler.sv
// Round-robin scheduler sharing one external combinational FP add/sub datapath among NUM_REQ clients.
// Optional FP_ADD_SCHED_STATS_EN adds saturating op/flag counters (stat_ops, stat_flags).
module fp_add_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_sub,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   rsp_flag,
  output logic [31:0]            add_para1,
  output logic [31:0]            add_para2,
  input  logic [31:0]            add_out,
  input  logic                   add_flag,
  output logic                   busy
`ifdef FP_ADD_SCHED_STATS_EN
  ,
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_flags
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   grant;
  logic [IDX_W-1:0]   cand;
  logic               grant_vld;
  logic [31:0]        win_a;
  logic [31:0]        win_b;
  logic               win_sub;
  logic               rsp_take;

  // Walk candidates from farthest to nearest so the nearest valid one after rr_ptr wins.
  always_comb begin
    grant_vld = 1'b0;
    grant     = '0;
    cand      = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_vld = 1'b1;
        grant     = cand;
      end
    end
  end

  always_comb begin
    win_a   = '0;
    win_b   = '0;
    win_sub = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDX_W'(i)) begin
        win_a   = req_a[32*i +: 32];
        win_b   = req_b[32*i +: 32];
        win_sub = req_sub[i];
      end
    end
  end

  assign req_ready = (state == IDLE && grant_vld) ? (NUM_REQ'(1) << grant) : '0;
  assign busy      = (state != IDLE);
  assign rsp_take  = (state == RESP) && rsp_ready[owner];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
      owner     <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_flag  <= 1'b0;
      add_para1 <= '0;
      add_para2 <= '0;
    end else begin
      case (state)
        IDLE: if (grant_vld) begin
          add_para1 <= win_a;
          // subtraction is an addition with B's sign flipped
          add_para2 <= {win_b[31] ^ win_sub, win_b[30:0]};
          owner     <= grant;
          rr_ptr    <= grant;
          state     <= EXEC;
        end
        EXEC: begin
          rsp_data  <= add_out;
          rsp_flag  <= add_flag;
          rsp_valid <= NUM_REQ'(1) << owner;
          state     <= RESP;
        end
        RESP: if (rsp_take) begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FP_ADD_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops   <= '0;
      stat_flags <= '0;
    end else if (rsp_take) begin
      if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
      if (rsp_flag && stat_flags != 16'hFFFF) stat_flags <= stat_flags + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_scheduler.sv
// Bench for fp_add_scheduler: transaction-level scoreboard checked every cycle, plus directed cases.
module tb_fp_add_scheduler;
  localparam int N = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_ready, req_sub, rsp_valid, rsp_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]     rsp_data, add_para1, add_para2, add_out;
  logic            rsp_flag, add_flag, busy;
`ifdef FP_ADD_SCHED_STATS_EN
  logic [15:0]     stat_ops, stat_flags;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fp_add_scheduler #(.NUM_REQ(N), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flag(rsp_flag),
    .add_para1(add_para1), .add_para2(add_para2),
    .add_out(add_out), .add_flag(add_flag),
    .busy(busy)
`ifdef FP_ADD_SCHED_STATS_EN
    , .stat_ops(stat_ops), .stat_flags(stat_flags)
`endif
  );

  // Simple truncating single-precision adder (normals, zero, overflow/underflow flagged).
  function automatic logic [32:0] fadd(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] p, q, t;
    longint mp, mq, sum;
    int ep, eq, e;
    p = x; q = y;
    if (p[30:0] < q[30:0]) begin t = p; p = q; q = t; end
    ep = int'(p[30:23]);
    eq = int'(q[30:23]);
    if (ep == 0) return 33'd0;
    mp = longint'({1'b1, p[22:0]}) << 3;
    mq = (eq == 0) ? 64'sd0 : longint'({1'b1, q[22:0]}) << 3;
    mq = (ep - eq > 40) ? 64'sd0 : (mq >>> (ep - eq));
    sum = (p[31] == q[31]) ? mp + mq : mp - mq;
    if (sum == 0) return 33'd0;
    e = ep;
    while (sum >= 64'sd134217728) begin sum = sum >>> 1; e++; end
    while (sum < 64'sd67108864) begin sum = sum <<< 1; e--; end
    if (e >= 255) return {1'b1, p[31], 8'hFF, 23'd0};
    if (e <= 0) return {1'b1, p[31], 31'd0};
    return {1'b0, p[31], 8'(e), sum[25:3]};
  endfunction

  always_comb {add_flag, add_out} = fadd(add_para1, add_para2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (last + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // ---------------- scoreboard ----------------
  logic [N-1:0] granted;
  bit           have_op;
  int           acc_cyc, cyc, m_own, m_last, g;
  logic [31:0]  m_pa1, m_pa2, m_res;
  logic         m_flag;
  logic [N-1:0] exp_rdy, exp_rv;
  int           m_ops, m_flags;

  always @(negedge clk) begin
    if (rst) begin
      have_op = 0; m_last = N - 1; m_pa1 = '0; m_pa2 = '0;
      m_ops = 0; m_flags = 0; granted = '0; cyc = 0; acc_cyc = 0;
    end else begin
      exp_rdy = '0; exp_rv = '0; granted = '0; g = -1;
      if (!have_op) begin
        g = pick(req_valid, m_last);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end else if (cyc - acc_cyc >= 2) begin
        exp_rv[m_own] = 1'b1;
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      chk("busy", 32'(busy), 32'(have_op));
      chk("add_para1", add_para1, m_pa1);
      chk("add_para2", add_para2, m_pa2);
      if (exp_rv != '0) begin
        chk("rsp_data", rsp_data, m_res);
        chk("rsp_flag", 32'(rsp_flag), 32'(m_flag));
      end
`ifdef FP_ADD_SCHED_STATS_EN
      chk("stat_ops", 32'(stat_ops), 32'(m_ops));
      chk("stat_flags", 32'(stat_flags), 32'(m_flags));
`endif
      if (g >= 0) begin
        have_op = 1; acc_cyc = cyc; m_own = g; m_last = g; granted[g] = 1'b1;
        m_pa1 = req_a[32*g +: 32];
        m_pa2 = req_b[32*g +: 32];
        m_pa2[31] = m_pa2[31] ^ req_sub[g];
        {m_flag, m_res} = fadd(m_pa1, m_pa2);
      end else if (have_op && cyc - acc_cyc >= 2 && rsp_ready[m_own]) begin
        have_op = 0;
        if (m_ops < 65535) m_ops++;
        if (m_flag && m_flags < 65535) m_flags++;
      end
      cyc++;
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] rand_fp();
    int sel;
    logic [7:0] ex;
    sel = $urandom_range(0, 19);
    if (sel == 0) ex = 8'd0;
    else if (sel == 1) ex = 8'd254;
    else ex = 8'($urandom_range(100, 154));
    return {1'($urandom), ex, 23'($urandom)};
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sub[i] = s;
    req_valid[i] = 1'b1;
  endtask

  task automatic pulse_rst();
    @(posedge clk); #1 rst = 1'b1; req_valid = '0; rsp_ready = '1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic do_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [31:0] ed, input logic ef, input string nm);
    logic [31:0] bb;
    bb = {b[31] ^ s, b[30:0]};
    @(posedge clk); #1 set_req(i, a, b, s);
    @(negedge clk); chk({nm, "_grant"}, 32'(req_ready), 32'(N'(1) << i));
    @(posedge clk); #1 req_valid[i] = 1'b0;
    @(negedge clk);
    chk({nm, "_exec_busy"}, 32'(busy), 32'd1);
    chk({nm, "_exec_rv"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_para1"}, add_para1, a);
    chk({nm, "_para2"}, add_para2, bb);
    @(negedge clk);
    chk({nm, "_rv"}, 32'(rsp_valid), 32'(N'(1) << i));
    chk({nm, "_data"}, rsp_data, ed);
    chk({nm, "_flag"}, 32'(rsp_flag), 32'(ef));
  endtask

  logic [32:0] r;
  int q[$];
  logic [31:0] held;
  bit idle_seen;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_sub = '0; rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_flag", 32'(rsp_flag), 32'd0);
    chk("rst_para1", add_para1, 32'd0);
    chk("rst_para2", add_para2, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    r = fadd(32'h3F800000, 32'h40000000); chk("pin_1p2", r[31:0], 32'h40400000);
    r = fadd(32'h40400000, 32'hBF800000); chk("pin_3m1", r[31:0], 32'h40000000);
    r = fadd(32'h7F7FFFFF, 32'h7F7FFFFF); chk("pin_ovf", {r[32], r[30:0]}, 32'hFF800000);

    do_op(0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, "op_1p2");
    do_op(1, 32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 1'b0, "op_3m1");
    chk("op_3m1_para2_lit", add_para2, 32'hBF800000);
    do_op(0, 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, "op_ovf");
    @(negedge clk);
`ifdef FP_ADD_SCHED_STATS_EN
    chk("stat_ops_3", 32'(stat_ops), 32'd3);
    chk("stat_flags_1", 32'(stat_flags), 32'd1);
`endif

    // both requesters continuously valid after reset: 0,1,0,1
    pulse_rst();
    set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    set_req(1, 32'h40400000, 32'h3F800000, 1'b1);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) if (req_ready[i]) q.push_back(i);
    end
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);
    chk("alt_count_ge4", 32'(q.size() >= 4), 32'd1);
    if (q.size() >= 4)
      for (int k = 0; k < 4; k++) chk("alt_order", 32'(q[k]), 32'(k % 2));

    // stalled response: rsp_ready[0] low for 5 RESP cycles
    pulse_rst();
    @(posedge clk); #1 set_req(0, 32'h3F800000, 32'h3F800000, 1'b0); rsp_ready = 3'b010;
    @(negedge clk); chk("stall_grant0", 32'(req_ready), 32'b001);
    @(posedge clk); #1 req_valid[0] = 1'b0; set_req(1, 32'h40000000, 32'h3F800000, 1'b0);
    @(negedge clk); chk("stall_exec_rdy", 32'(req_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_rv", 32'(rsp_valid), 32'b001);
      chk("stall_data", rsp_data, 32'h40000000);
      chk("stall_rdy", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1 rsp_ready = 3'b011;
    @(negedge clk);
    chk("release_rv", 32'(rsp_valid), 32'b001);
    chk("release_rdy", 32'(req_ready), 32'd0);
    @(negedge clk); chk("after_release_grant1", 32'(req_ready), 32'b010);
    @(posedge clk); #1 req_valid = '0; rsp_ready = '1;
    repeat (4) @(posedge clk);

    // reset during EXEC discards the op and restarts round-robin at 0
    pulse_rst();
    @(posedge clk); #1 set_req(0, 32'h3F800000, 32'h40000000, 1'b0);
    @(negedge clk); chk("rexec_grant0", 32'(req_ready), 32'b001);
    @(posedge clk); #1 rst = 1'b1; set_req(1, 32'h3F800000, 32'h3F800000, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rexec_busy", 32'(busy), 32'd0);
    chk("rexec_rv", 32'(rsp_valid), 32'd0);
    chk("rexec_grant0_again", 32'(req_ready), 32'b001);
    @(posedge clk); #1 req_valid = '0;
    repeat (4) @(posedge clk);

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || granted[i]) begin
          if ($urandom_range(0, 9) < 6) set_req(i, rand_fp(), rand_fp(), 1'($urandom));
          else req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 19) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = N'($urandom);
    end

    @(posedge clk); #1 rst = 1'b0; req_valid = '0; rsp_ready = '1;
    idle_seen = 0;
    for (int c = 0; c < 10 && !idle_seen; c++) begin
      @(negedge clk);
      if (!busy) idle_seen = 1;
    end
    chk("drain_idle", 32'(idle_seen), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
